hilo_spec_regfile: RTL and testbench
====================================

# hilo_spec_regfile

Speculative HI/LO register file downstream of the multiply/divide unit. It accepts HI/LO write requests (MUL/DIV results and MTHI/MTLO), holds them in an in-order pending queue until the retire stage commits them, and drops them on a pipeline flush. It serves MFHI/MFLO reads and returns the youngest {HI,LO} view to the MDU as the accumulate operand.

## Interface
- `DEPTH`, default 2: pending-queue entries; a power of two, at least 2.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-low.
- `wr_valid` in 1: write request from the MDU, one per MDU operation.
- `wr_en` in 2: per-half enable. Bit1 = HI, bit0 = LO; 2'b11 for MUL/DIV.
- `wr_data` in 64: [63:32] = HI value, [31:0] = LO value.
- `wr_ready` out 1: the queue can accept a write this cycle.
- `commit` in 1: retire the oldest pending entry into the architectural registers.
- `flush` in 1: discard all pending entries.
- `hilo_busy` in 1: an MDU operation is in flight; HI/LO reads must wait.
- `rd_req` in 1: MFHI/MFLO request.
- `rd_sel` in 1: 1 = HI, 0 = LO.
- `rd_ok` out 1: read accepted this cycle.
- `rd_data` out 32: read value; valid when `rd_ok` = 1.
- `hilo_data` out 64: speculative {HI,LO}; feeds the MDU HiLoData operand.
- `arch_hi` out 32: committed HI.
- `arch_lo` out 32: committed LO.
- `pending_cnt` out clog2(DEPTH)+1: number of occupied queue entries.

## Operation
- **State:**
  - `arch_hi` and `arch_lo`.
  - Circular queue of DEPTH entries, each holding {en[1:0], data[63:0]}.
  - Head pointer, tail pointer and count.
- **Push:** when `wr_valid && wr_ready`, write {`wr_en`, `wr_data`} at the tail; tail+1 (mod DEPTH); count+1.
  - `wr_valid` with `wr_en` = 2'b00 still allocates an entry.
  - `wr_ready = (count != DEPTH)`. Same-cycle commit is not credited.
  - A `wr_valid` that is not accepted is ignored; the source holds it.
- **Commit:** when `commit && count != 0`:
  - Copy the enabled halves of the head entry into the architectural registers (HI from data[63:32], LO from data[31:0]).
  - Head+1 (mod DEPTH); count-1.
  - `commit` with count = 0 is ignored.
- **Simultaneous push and commit:** both take effect and count is unchanged. When count = 1, the committed entry is the old head, not the new write.
- **Flush:**
  - Commit, if requested in the same cycle, is applied first.
  - All remaining entries are then discarded: head = tail = 0, count = 0.
  - A push in the flush cycle is dropped.
  - The architectural registers are otherwise untouched.
- **Speculative view:** start from {`arch_hi`, `arch_lo`}. Overlay each valid entry from head to tail, per half, when its enable bit is set, so the youngest write wins. `hilo_data` is this view, combinational from registered state.
- **Read:**
  - `rd_ok = rd_req && !hilo_busy && !wr_valid && !flush`.
  - `rd_data` = HI or LO of the speculative view, selected by `rd_sel`.
  - There is no same-cycle write-to-read bypass; a read waits while a write is presented.
- **Reset** (`rst` = 0 at a clk edge):
  - `arch_hi`, `arch_lo`, pointers and count all go to 0.
  - Queue contents are don't-care.
  - Reset overrides any concurrent push, commit or flush.
  - While `rst` = 0: `wr_ready` = 0 and `rd_ok` = 0.

## Timing
- **Output values after reset:**
  - `wr_ready` = 1, `rd_ok` = 0 (until `rd_req`), `rd_data` = 0.
  - `hilo_data`, `arch_hi`, `arch_lo` = 0.
  - `pending_cnt` = 0.
- **Push:** a write accepted at edge N appears in `hilo_data` / `rd_data` and `pending_cnt` from cycle N+1.
- **Commit:** a commit at edge N updates `arch_*` from cycle N+1. `hilo_data` does not change, because the data was already in the speculative view.
- **Flush:** a flush at edge N makes `hilo_data` equal the (possibly just-committed) architectural values from cycle N+1.
- **Read:** zero latency. `rd_ok` and `rd_data` are combinational in the request cycle.
- **Throughput:** one push and one commit per cycle sustained with no bubbles when DEPTH ≥ 2.
- **Full queue:** a full queue blocks pushes for the cycle in which the commit happens; `wr_ready` rises the cycle after.

## Test plan
- **Reset then read:** reset, then `rd_req=1, rd_sel=1` → `rd_ok`=1, `rd_data`=0, `pending_cnt`=0.
- **Push, forward, commit:**
  - Push `wr_en`=11, data=64'h11112222_33334444 → next cycle `hilo_data`=64'h11112222_33334444, `arch_hi`=0.
  - `commit` → next cycle `arch_hi`=32'h11112222, `arch_lo`=32'h33334444.
- **Youngest-wins partial writes:**
  - Push 11/{A,B}, then push 01/{X,C} → `hilo_data`={A,C}, MFHI=A, MFLO=C.
  - Two commits → `arch` = {A,C}.
- **Full, and commit with push:** with DEPTH=2, two pushes → `wr_ready`=0, `pending_cnt`=2. A commit plus a held `wr_valid` → the push is accepted the next cycle and count returns to 2.
- **Flush with same-cycle commit:**
  - Two pending entries {1,2} and {3,4}; assert `commit`+`flush`+`wr_valid` → `arch`={1,2}, count=0, `hilo_data`={1,2`}`, and the new write is dropped.
- **Read blocking and reset mid-operation:**
  - `rd_req` with `hilo_busy`=1 → `rd_ok`=0; the same request with `wr_valid`=1 → `rd_ok`=0.
  - Reset asserted with 2 pending entries and `commit`=1 → all state is 0 the next cycle.

Source files
------------

// File: rtl/hilo_spec_regfile.sv
// hilo_spec_regfile: speculative HI/LO register file with an in-order pending queue (push wr_*, retire commit, drop flush, read rd_*, views hilo_data/arch_*/pending_cnt)
module hilo_spec_regfile #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [1:0]                 wr_en,
  input  logic [63:0]                wr_data,
  output logic                       wr_ready,
  input  logic                       commit,
  input  logic                       flush,
  input  logic                       hilo_busy,
  input  logic                       rd_req,
  input  logic                       rd_sel,
  output logic                       rd_ok,
  output logic [31:0]                rd_data,
  output logic [63:0]                hilo_data,
  output logic [31:0]                arch_hi,
  output logic [31:0]                arch_lo,
  output logic [$clog2(DEPTH):0]     pending_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [65:0]   q [DEPTH];
  logic [AW-1:0] head, tail, idx;
  logic [AW:0]   cnt;
  logic          push, pop;
  assign wr_ready = rst && cnt != (AW+1)'(DEPTH);
  assign push = wr_valid && wr_ready && !flush;
  assign pop = commit && cnt != '0;
  assign pending_cnt = cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      arch_hi <= '0;
      arch_lo <= '0;
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      if (pop) begin
        if (q[head][65]) arch_hi <= q[head][63:32];
        if (q[head][64]) arch_lo <= q[head][31:0];
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt <= '0;
      end else begin
        if (push) begin
          q[tail] <= {wr_en, wr_data};
          tail <= tail + AW'(1);
        end
        if (pop) head <= head + AW'(1);
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  always_comb begin
    hilo_data = {arch_hi, arch_lo};
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((AW+1)'(i) < cnt) begin
        if (q[idx][65]) hilo_data[63:32] = q[idx][63:32];
        if (q[idx][64]) hilo_data[31:0] = q[idx][31:0];
      end
    end
  end
  assign rd_ok = rst && rd_req && !hilo_busy && !wr_valid && !flush;
  assign rd_data = rd_sel ? hilo_data[63:32] : hilo_data[31:0];
endmodule

// File: tb/tb_hilo_spec_regfile.sv
// tb_hilo_spec_regfile: directed self-checking bench for hilo_spec_regfile with DEPTH=2
module tb_hilo_spec_regfile;
  logic        clk = 0;
  logic        rst, wr_valid, commit, flush, hilo_busy, rd_req, rd_sel;
  logic [1:0]  wr_en;
  logic [63:0] wr_data;
  logic        wr_ready, rd_ok;
  logic [31:0] rd_data, arch_hi, arch_lo;
  logic [63:0] hilo_data;
  logic [1:0]  pending_cnt;
  int n_chk = 0, n_fail = 0;
  localparam logic [31:0] A = 32'hAAAA0001, B = 32'hBBBB0002, X = 32'hCCCC0003, C = 32'hDDDD0004;
  localparam logic [63:0] P1 = 64'h11112222_33334444, D1 = 64'hEEEE0005_FFFF0006;
  localparam logic [63:0] F12 = 64'h00000001_00000002, F34 = 64'h00000003_00000004;
  hilo_spec_regfile #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .commit(commit), .flush(flush), .hilo_busy(hilo_busy),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ok(rd_ok), .rd_data(rd_data),
    .hilo_data(hilo_data), .arch_hi(arch_hi), .arch_lo(arch_lo), .pending_cnt(pending_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 0; wr_valid = 0; wr_en = 0; wr_data = 0; commit = 0; flush = 0;
    hilo_busy = 0; rd_req = 1; rd_sel = 1;
    tick(); tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ok", rd_ok, 0);
    rst = 1; #1;
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_rd_ok", rd_ok, 1);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_hilo", hilo_data, 0);
    chk("reset_arch_hi", arch_hi, 0);
    chk("reset_arch_lo", arch_lo, 0);
    chk("reset_cnt", pending_cnt, 0);
    rd_req = 0;
    wr_valid = 1; wr_en = 2'b11; wr_data = P1;
    tick(); wr_valid = 0; #1;
    chk("push_hilo", hilo_data, P1);
    chk("push_arch_hi", arch_hi, 0);
    chk("push_cnt", pending_cnt, 1);
    commit = 1;
    tick(); commit = 0; #1;
    chk("commit_arch_hi", arch_hi, 32'h11112222);
    chk("commit_arch_lo", arch_lo, 32'h33334444);
    chk("commit_hilo", hilo_data, P1);
    chk("commit_cnt", pending_cnt, 0);
    wr_valid = 1; wr_en = 2'b11; wr_data = {A, B};
    tick(); wr_en = 2'b01; wr_data = {X, C};
    tick(); wr_valid = 0; #1;
    chk("yw_hilo", hilo_data, {A, C});
    chk("yw_cnt", pending_cnt, 2);
    chk("full_wr_ready", wr_ready, 0);
    rd_req = 1; rd_sel = 1; #1;
    chk("mfhi_ok", rd_ok, 1);
    chk("mfhi_data", rd_data, A);
    rd_sel = 0; #1;
    chk("mflo_data", rd_data, C);
    rd_req = 0;
    commit = 1; wr_valid = 1; wr_en = 2'b11; wr_data = D1; #1;
    chk("full_commit_ready", wr_ready, 0);
    tick(); commit = 0; #1;
    chk("c1_cnt", pending_cnt, 1);
    chk("c1_ready", wr_ready, 1);
    chk("c1_arch_hi", arch_hi, A);
    chk("c1_arch_lo", arch_lo, B);
    tick(); wr_valid = 0; #1;
    chk("held_push_cnt", pending_cnt, 2);
    chk("held_push_hilo", hilo_data, D1);
    commit = 1;
    tick();
    chk("c2_arch", {arch_hi, arch_lo}, {A, C});
    tick(); commit = 0; #1;
    chk("c3_arch", {arch_hi, arch_lo}, D1);
    chk("c3_cnt", pending_cnt, 0);
    wr_valid = 1; wr_en = 2'b00; wr_data = 64'hDEAD_BEEF_0000_0000;
    tick(); wr_valid = 0; #1;
    chk("en00_cnt", pending_cnt, 1);
    chk("en00_hilo", hilo_data, D1);
    commit = 1;
    tick(); commit = 0; #1;
    chk("en00_commit_arch", {arch_hi, arch_lo}, D1);
    wr_valid = 1; wr_en = 2'b11; wr_data = F12;
    tick(); wr_data = F34;
    tick(); wr_data = 64'h5; commit = 1; flush = 1; #1;
    chk("flush_rd_ok", rd_ok, 0);
    tick(); wr_valid = 0; commit = 0; flush = 0; #1;
    chk("flush_arch", {arch_hi, arch_lo}, F12);
    chk("flush_cnt", pending_cnt, 0);
    chk("flush_hilo", hilo_data, F12);
    wr_valid = 1; wr_data = 64'h00000007_00000008;
    tick(); wr_data = 64'h00000009_0000000A; flush = 1;
    tick(); wr_valid = 0; flush = 0; #1;
    chk("flush_drop_cnt", pending_cnt, 0);
    chk("flush_drop_hilo", hilo_data, F12);
    chk("flush_drop_arch", {arch_hi, arch_lo}, F12);
    rd_req = 1; hilo_busy = 1; #1;
    chk("busy_rd_ok", rd_ok, 0);
    hilo_busy = 0; wr_valid = 1; #1;
    chk("wr_rd_ok", rd_ok, 0);
    wr_valid = 0; #1;
    chk("free_rd_ok", rd_ok, 1);
    rd_req = 0;
    wr_valid = 1; wr_data = F34;
    tick(); tick(); wr_valid = 0; #1;
    chk("pre_rst_cnt", pending_cnt, 2);
    commit = 1; rst = 0;
    tick(); commit = 0; #1;
    chk("midrst_arch", {arch_hi, arch_lo}, 0);
    chk("midrst_cnt", pending_cnt, 0);
    chk("midrst_hilo", hilo_data, 0);
    chk("midrst_ready", wr_ready, 0);
    rst = 1; #1;
    chk("post_rst_ready", wr_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
